// File: rtl/elevator_pkg.sv
// Shared types, widths and call-search helpers for the N-floor elevator controller.
package elevator_pkg;

  localparam int unsigned MaxFloors = 16;
  localparam int unsigned FloorW    = 4;
  localparam int unsigned OccW      = 5;
  localparam int unsigned TimerW    = 8;

  typedef enum logic [1:0] {
    StIdle,
    StMoving,
    StDoorOpen
  } state_e;

  function automatic logic has_calls_above(input logic [MaxFloors-1:0] pending,
                                           input logic [FloorW-1:0]    floor);
    logic found;
    found = 1'b0;
    for (int i = 0; i < MaxFloors; i++) begin
      if (i > int'(floor) && pending[i]) found = 1'b1;
    end
    return found;
  endfunction

  function automatic logic has_calls_below(input logic [MaxFloors-1:0] pending,
                                           input logic [FloorW-1:0]    floor);
    logic found;
    found = 1'b0;
    for (int i = 0; i < MaxFloors; i++) begin
      if (i < int'(floor) && pending[i]) found = 1'b1;
    end
    return found;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Free-running divider: one-cycle tick every CLK_FREQ clocks, restarted by reset.
module sec_tick_gen #(
  parameter int unsigned CLK_FREQ = 500
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CntW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_FREQ - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CntMax);

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/elevator_ctrl_n.sv
// N-floor elevator controller: SCAN call service, tick-timed travel/door phases,
// occupancy tracking with overweight door hold, and an SOS hold mode.
module elevator_ctrl_n
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS   = 8,
  parameter int unsigned CLK_FREQ     = 500,
  parameter int unsigned TRAVEL_TICKS = 2,
  parameter int unsigned DOOR_TICKS   = 3,
  parameter int unsigned MAX_PEOPLE   = 6
) (
  input  logic                  clk_50,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic                  sos_flip,
  input  logic                  person_in,
  input  logic                  person_out,
  output logic [NUM_FLOORS-1:0] call_led,
  output logic [NUM_FLOORS-1:0] floor_onehot,
  output logic                  door,
  output logic                  moving,
  output logic                  dir_up,
  output logic                  sos_mode,
  output logic                  weight_limit_exceeded
);

  localparam logic [FloorW-1:0] TopFloor   = FloorW'(NUM_FLOORS - 1);
  localparam logic [TimerW-1:0] TravelLast = TimerW'(TRAVEL_TICKS - 1);
  localparam logic [TimerW-1:0] DoorLast   = TimerW'(DOOR_TICKS - 1);
  localparam logic [OccW-1:0]   OccFull    = '1;
  localparam logic [OccW-1:0]   OccLimit   = OccW'(MAX_PEOPLE);

  state_e                  state_q, state_d;
  logic [FloorW-1:0]       floor_q, floor_d;
  logic                    dir_up_q, dir_up_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [TimerW-1:0]       timer_q, timer_d;
  logic [OccW-1:0]         occ_q, occ_d;
  logic                    sos_q, sos_d;
  logic                    door_q, door_d;
  logic                    moving_q, moving_d;
  logic                    wle_q, wle_d;
  logic [NUM_FLOORS-1:0]   floor_oh_q, floor_oh_d;

  logic                    tick;
  logic [MaxFloors-1:0]    pend_wide;
  logic [NUM_FLOORS-1:0]   here_mask;
  logic [NUM_FLOORS-1:0]   next_mask;
  logic [NUM_FLOORS-1:0]   call_eff;
  logic [FloorW-1:0]       floor_next;
  logic                    here_call;
  logic                    calls_above;
  logic                    calls_below;
  logic                    next_called;
  logic                    next_ahead;
  logic                    sos_enter;
  logic                    sos_exit;

  sec_tick_gen #(
    .CLK_FREQ(CLK_FREQ)
  ) u_tick (
    .clk_i (clk_50),
    .rst_i (reset),
    .tick_o(tick)
  );

  assign pend_wide   = MaxFloors'(pending_q);
  assign floor_next  = dir_up_q ? floor_q + FloorW'(1) : floor_q - FloorW'(1);
  assign here_mask   = NUM_FLOORS'(1) << floor_q;
  assign next_mask   = NUM_FLOORS'(1) << floor_next;
  assign here_call   = ~sos_q & (|(call_req & here_mask));
  assign calls_above = has_calls_above(pend_wide, floor_q);
  assign calls_below = has_calls_below(pend_wide, floor_q);
  assign next_called = |(pending_q & next_mask);
  assign next_ahead  = dir_up_q ? has_calls_above(pend_wide, floor_next)
                                : has_calls_below(pend_wide, floor_next);
  assign sos_enter   = sos_flip & ~sos_q;
  assign sos_exit    = sos_flip & sos_q;

  // A call for the floor the car is parked at opens the door instead of latching.
  always_comb begin
    call_eff = '0;
    if (!sos_q) begin
      call_eff = call_req & ((state_q == StMoving) ? '1 : ~here_mask);
    end
  end

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_up_d  = dir_up_q;
    timer_d   = timer_q;
    pending_d = pending_q | call_eff;
    if (sos_enter) pending_d = '0;

    unique case (state_q)
      StIdle: begin
        if (floor_q == '0) begin
          dir_up_d = 1'b1;
        end else if (floor_q == TopFloor) begin
          dir_up_d = 1'b0;
        end
        if (sos_q || here_call) begin
          state_d = StDoorOpen;
          timer_d = '0;
        end else if (|pending_q) begin
          // SCAN: keep heading while anything lies ahead, otherwise turn round.
          dir_up_d = dir_up_q ? calls_above : ~calls_below;
          state_d  = StMoving;
          timer_d  = '0;
        end
      end
      StMoving: begin
        if (tick) begin
          if (timer_q == TravelLast) begin
            floor_d = floor_next;
            timer_d = '0;
            if (sos_q || next_called || !next_ahead) begin
              state_d   = StDoorOpen;
              pending_d = pending_d & ~next_mask;
            end
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
      end
      StDoorOpen: begin
        if (here_call || sos_exit) begin
          timer_d = '0;
        end else if (tick && !wle_q && !sos_q) begin
          if (timer_q == DoorLast) begin
            state_d = StIdle;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    if (door_q) begin
      if (person_in && !person_out && occ_q != OccFull) begin
        occ_d = occ_q + OccW'(1);
      end else if (person_out && !person_in && occ_q != '0) begin
        occ_d = occ_q - OccW'(1);
      end
    end
    wle_d      = (occ_d > OccLimit);
    sos_d      = sos_q ^ sos_flip;
    door_d     = (state_d == StDoorOpen);
    moving_d   = (state_d == StMoving);
    floor_oh_d = NUM_FLOORS'(1) << floor_d;
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q    <= StIdle;
      floor_q    <= '0;
      dir_up_q   <= 1'b1;
      pending_q  <= '0;
      timer_q    <= '0;
      occ_q      <= '0;
      sos_q      <= 1'b0;
      door_q     <= 1'b0;
      moving_q   <= 1'b0;
      wle_q      <= 1'b0;
      floor_oh_q <= NUM_FLOORS'(1);
    end else begin
      state_q    <= state_d;
      floor_q    <= floor_d;
      dir_up_q   <= dir_up_d;
      pending_q  <= pending_d;
      timer_q    <= timer_d;
      occ_q      <= occ_d;
      sos_q      <= sos_d;
      door_q     <= door_d;
      moving_q   <= moving_d;
      wle_q      <= wle_d;
      floor_oh_q <= floor_oh_d;
    end
  end

  assign call_led              = pending_q;
  assign floor_onehot          = floor_oh_q;
  assign door                  = door_q;
  assign moving                = moving_q;
  assign dir_up                = dir_up_q;
  assign sos_mode              = sos_q;
  assign weight_limit_exceeded = wle_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Bench for elevator_ctrl_n: directed scenarios plus random traffic, every cycle
// compared against a behavioural car model kept in plain integers.
module tb_elevator_ctrl_n;

  localparam int NF = 8;
  localparam int CF = 4;
  localparam int TT = 2;
  localparam int DT = 3;
  localparam int MP = 6;

  logic          clk_50 = 1'b0;
  logic          reset = 1'b1;
  logic [NF-1:0] call_req = '0;
  logic          sos_flip = 1'b0;
  logic          person_in = 1'b0;
  logic          person_out = 1'b0;
  logic [NF-1:0] call_led;
  logic [NF-1:0] floor_onehot;
  logic          door;
  logic          moving;
  logic          dir_up;
  logic          sos_mode;
  logic          weight_limit_exceeded;

  always #5 clk_50 = ~clk_50;

  elevator_ctrl_n #(
    .NUM_FLOORS  (NF),
    .CLK_FREQ    (CF),
    .TRAVEL_TICKS(TT),
    .DOOR_TICKS  (DT),
    .MAX_PEOPLE  (MP)
  ) dut (
    .clk_50               (clk_50),
    .reset                (reset),
    .call_req             (call_req),
    .sos_flip             (sos_flip),
    .person_in            (person_in),
    .person_out           (person_out),
    .call_led             (call_led),
    .floor_onehot         (floor_onehot),
    .door                 (door),
    .moving               (moving),
    .dir_up               (dir_up),
    .sos_mode             (sos_mode),
    .weight_limit_exceeded(weight_limit_exceeded)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Car model: phase 0 = parked, 1 = travelling, 2 = door open.
  int m_phase, m_floor, m_timer, m_occ, m_cyc;
  bit m_dir, m_sos, m_wle;
  bit m_pend[NF];

  function automatic bit any_pending(input int lo, input int hi);
    bit r = 1'b0;
    for (int i = 0; i < NF; i++) if (i >= lo && i <= hi && m_pend[i]) r = 1'b1;
    return r;
  endfunction

  task automatic model_step();
    bit np[NF];
    bit tick, ahead;
    int f, nf, t;
    bit d, sos, wle;
    if (reset) begin
      m_phase = 0; m_floor = 0; m_timer = 0; m_occ = 0; m_cyc = 0;
      m_dir = 1'b1; m_sos = 1'b0; m_wle = 1'b0;
      for (int i = 0; i < NF; i++) m_pend[i] = 1'b0;
      return;
    end
    tick  = (m_cyc % CF) == CF - 1;
    m_cyc = m_cyc + 1;
    f = m_floor; t = m_timer; d = m_dir; sos = m_sos; wle = m_wle;
    np = m_pend;
    if (!sos) begin
      for (int i = 0; i < NF; i++) begin
        if (call_req[i] && !(i == f && m_phase != 1)) np[i] = 1'b1;
      end
    end
    if (sos_flip && !sos) for (int i = 0; i < NF; i++) np[i] = 1'b0;
    if (m_phase == 2) begin
      if (person_in && !person_out && m_occ < 31) m_occ++;
      else if (person_out && !person_in && m_occ > 0) m_occ--;
    end
    case (m_phase)
      0: begin
        if (f == 0) m_dir = 1'b1;
        else if (f == NF - 1) m_dir = 1'b0;
        if (sos || call_req[f]) begin
          m_phase = 2; m_timer = 0;
        end else if (any_pending(0, NF - 1)) begin
          m_dir   = d ? any_pending(f + 1, NF - 1) : !any_pending(0, f - 1);
          m_phase = 1; m_timer = 0;
        end
      end
      1: begin
        if (tick) begin
          if (t == TT - 1) begin
            nf = d ? f + 1 : f - 1;
            m_floor = nf; m_timer = 0;
            ahead = d ? any_pending(nf + 1, NF - 1) : any_pending(0, nf - 1);
            if (sos || m_pend[nf] || !ahead) begin
              m_phase = 2; np[nf] = 1'b0;
            end
          end else begin
            m_timer = t + 1;
          end
        end
      end
      default: begin
        if ((!sos && call_req[f]) || (sos_flip && sos)) begin
          m_timer = 0;
        end else if (tick && !wle && !sos) begin
          if (t == DT - 1) begin
            m_phase = 0; m_timer = 0;
          end else begin
            m_timer = t + 1;
          end
        end
      end
    endcase
    m_sos  = sos ^ sos_flip;
    m_wle  = m_occ > MP;
    m_pend = np;
  endtask

  task automatic compare_all();
    logic [NF-1:0] led;
    for (int i = 0; i < NF; i++) led[i] = m_pend[i];
    check_eq("call_led", 32'(call_led), 32'(led));
    check_eq("floor_onehot", 32'(floor_onehot), 32'(1) << m_floor);
    check_eq("door", 32'(door), 32'(m_phase == 2));
    check_eq("moving", 32'(moving), 32'(m_phase == 1));
    check_eq("dir_up", 32'(dir_up), 32'(m_dir));
    check_eq("sos_mode", 32'(sos_mode), 32'(m_sos));
    check_eq("weight_limit", 32'(weight_limit_exceeded), 32'(m_wle));
  endtask

  task automatic step();
    @(posedge clk_50);
    model_step();
    #1;
    compare_all();
    call_req = '0; sos_flip = 1'b0; person_in = 1'b0; person_out = 1'b0;
  endtask

  task automatic run_until_door(input bit want, input int budget, input string tag,
                                output int cycles);
    cycles = 0;
    while (door !== want && cycles < budget) begin
      step();
      cycles++;
    end
    check_eq(tag, 32'(door), 32'(want));
  endtask

  task automatic run_until_floor(input int f, input int budget, input string tag);
    int n = 0;
    logic [NF-1:0] oh;
    oh = NF'(1) << f;
    while ((floor_onehot !== oh || moving !== 1'b1) && n < budget) begin
      step();
      n++;
    end
    check_eq(tag, 32'(floor_onehot), 32'(oh));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset values.
    step();
    do_reset();
    check_eq("rst_floor", 32'(floor_onehot), 32'h01);
    check_eq("rst_door", 32'(door), 32'h0);
    check_eq("rst_moving", 32'(moving), 32'h0);
    check_eq("rst_led", 32'(call_led), 32'h0);
    check_eq("rst_sos", 32'(sos_mode), 32'h0);
    check_eq("rst_dir", 32'(dir_up), 32'h1);

    // Single call from the ground floor.
    call_req = 8'h08;
    step();
    check_eq("led_f3", 32'(call_led), 32'h08);
    step();
    check_eq("depart_moving", 32'(moving), 32'h1);
    run_until_door(1'b1, 80, "arrive_f3", n);
    check_eq("at_f3", 32'(floor_onehot), 32'h08);
    check_eq("led_cleared_f3", 32'(call_led), 32'h00);
    run_until_door(1'b0, 40, "door_close_f3", n);
    check_eq("door_time_f3", 32'(n), 32'd12);

    // SCAN: up to 6 first, then back down to 1.
    call_req = 8'h42;
    step();
    run_until_door(1'b1, 120, "arrive_f6", n);
    check_eq("at_f6", 32'(floor_onehot), 32'h40);
    check_eq("led_f1_left", 32'(call_led), 32'h02);
    run_until_door(1'b0, 40, "door_close_f6", n);
    check_eq("dir_kept_at_close", 32'(dir_up), 32'h1);
    step();
    check_eq("dir_reversed_idle", 32'(dir_up), 32'h0);
    run_until_door(1'b1, 160, "arrive_f1", n);
    check_eq("at_f1", 32'(floor_onehot), 32'h02);

    // Overweight holds the door; one leaving releases it.
    for (int i = 0; i < 7; i++) begin
      person_in = 1'b1;
      step();
    end
    check_eq("overweight", 32'(weight_limit_exceeded), 32'h1);
    for (int i = 0; i < 40; i++) step();
    check_eq("door_held_heavy", 32'(door), 32'h1);
    person_out = 1'b1;
    step();
    check_eq("weight_ok", 32'(weight_limit_exceeded), 32'h0);
    run_until_door(1'b0, 16, "door_close_after_out", n);

    // SOS while travelling 2 -> 3.
    do_reset();
    call_req = 8'h20;
    step();
    run_until_floor(2, 120, "reach_f2");
    sos_flip = 1'b1;
    step();
    check_eq("sos_on", 32'(sos_mode), 32'h1);
    check_eq("sos_led_clear", 32'(call_led), 32'h00);
    run_until_door(1'b1, 40, "sos_stop", n);
    check_eq("sos_at_f3", 32'(floor_onehot), 32'h08);
    call_req = 8'hff;
    step();
    check_eq("sos_call_ignored", 32'(call_led), 32'h00);
    for (int i = 0; i < 30; i++) step();
    check_eq("sos_door_held", 32'(door), 32'h1);
    sos_flip = 1'b1;
    step();
    check_eq("sos_off", 32'(sos_mode), 32'h0);
    run_until_door(1'b0, 20, "sos_exit_close", n);
    check_eq("sos_exit_door_time", 32'(n >= 8 && n <= 12), 32'h1);

    // Reset mid-travel clears position and occupancy.
    do_reset();
    call_req = 8'h01;
    step();
    check_eq("call_here_door", 32'(door), 32'h1);
    for (int i = 0; i < 7; i++) begin
      person_in = 1'b1;
      step();
    end
    person_out = 1'b1;
    step();
    call_req = 8'h80;
    step();
    run_until_floor(5, 200, "reach_f5");
    do_reset();
    check_eq("midtravel_rst_floor", 32'(floor_onehot), 32'h01);
    check_eq("midtravel_rst_moving", 32'(moving), 32'h0);
    check_eq("midtravel_rst_led", 32'(call_led), 32'h00);
    call_req = 8'h01;
    step();
    check_eq("rst_call_here_door", 32'(door), 32'h1);
    check_eq("rst_call_here_led", 32'(call_led), 32'h00);
    person_in = 1'b1;
    step();
    check_eq("occ_was_reset", 32'(weight_limit_exceeded), 32'h0);

    // Random traffic against the model.
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 7) == 0) call_req = NF'(1) << $urandom_range(0, NF - 1);
      person_in  = ($urandom_range(0, 5) == 0);
      person_out = ($urandom_range(0, 4) == 0);
      sos_flip   = ($urandom_range(0, 299) == 0);
      reset      = ($urandom_range(0, 999) == 0);
      step();
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
